// File: rtl/trace_dumper.sv
`default_nettype none
// ============================================================================
// Module   : trace_dumper
// Purpose  : Reads trace buffer entries over a split-memory master port and
//            streams each one as a little-endian byte record.
//            Define TRACE_DUMP_CHK_EN to append an XOR checksum byte.
// Revision : 1.0
// ============================================================================
module trace_dumper #(
    parameter int CAPACITY = 256,
    localparam int IDX_W = $clog2(CAPACITY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dump_start_i,
    input  logic [IDX_W:0]   entry_cnt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             trace_req_o,
    input  logic             trace_ack_i,
    output logic [31:0]      trace_addr_o,
    output logic             trace_we_o,
    output logic [31:0]      trace_wdata_o,
    input  logic [31:0]      trace_rdata_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i
);

    localparam logic [IDX_W:0] c_CAP = (IDX_W+1)'(CAPACITY);
`ifdef TRACE_DUMP_CHK_EN
    localparam logic [3:0] c_LAST_BYTE = 4'd9;
`else
    localparam logic [3:0] c_LAST_BYTE = 4'd8;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_CAP = 3'd2,
        S_SEND   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W:0]   r_cnt;
    logic [IDX_W:0]   r_idx;
    logic [1:0]       r_f;
    logic [3:0]       r_b;
    logic [31:0]      r_addr_fld;
    logic [31:0]      r_data_fld;
    logic             r_we_fld;

    logic [IDX_W:0]   w_cnt_clamp;
    logic [IDX_W:0]   w_idx_inc;
    logic             w_last_entry;
    logic             w_byte_done;
    logic [7:0]       w_byte;

    assign w_cnt_clamp  = (entry_cnt_i > c_CAP) ? c_CAP : entry_cnt_i;
    assign w_idx_inc    = r_idx + 1'b1;
    assign w_last_entry = (w_idx_inc == r_cnt);
    assign w_byte_done  = tx_ready_i && (r_b == c_LAST_BYTE);

    assign trace_we_o    = 1'b0;
    assign trace_wdata_o = 32'h0000_0000;

`ifdef TRACE_DUMP_CHK_EN
    logic [7:0] w_chk;
    assign w_chk = r_addr_fld[7:0]   ^ r_addr_fld[15:8] ^
                   r_addr_fld[23:16] ^ r_addr_fld[31:24] ^
                   r_data_fld[7:0]   ^ r_data_fld[15:8] ^
                   r_data_fld[23:16] ^ r_data_fld[31:24] ^
                   {7'b0, r_we_fld};
`endif

    always_comb begin
        w_byte = 8'h00;
        case (r_b)
            4'd0:    w_byte = r_addr_fld[7:0];
            4'd1:    w_byte = r_addr_fld[15:8];
            4'd2:    w_byte = r_addr_fld[23:16];
            4'd3:    w_byte = r_addr_fld[31:24];
            4'd4:    w_byte = r_data_fld[7:0];
            4'd5:    w_byte = r_data_fld[15:8];
            4'd6:    w_byte = r_data_fld[23:16];
            4'd7:    w_byte = r_data_fld[31:24];
            4'd8:    w_byte = {7'b0, r_we_fld};
`ifdef TRACE_DUMP_CHK_EN
            4'd9:    w_byte = w_chk;
`endif
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        busy_o       = (r_state != S_IDLE);
        done_o       = 1'b0;
        trace_req_o  = 1'b0;
        trace_addr_o = 32'h0000_0000;
        tx_valid_o   = 1'b0;
        tx_data_o    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (dump_start_i) begin
                    w_next = (w_cnt_clamp == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                trace_req_o  = 1'b1;
                trace_addr_o = {{(30-IDX_W){1'b0}}, r_idx[IDX_W-1:0], r_f};
                if (trace_ack_i) begin
                    w_next = S_RD_CAP;
                end
            end
            S_RD_CAP: begin
                w_next = (r_f == 2'd2) ? S_SEND : S_RD_REQ;
            end
            S_SEND: begin
                tx_valid_o = 1'b1;
                tx_data_o  = w_byte;
                if (w_byte_done) begin
                    w_next = w_last_entry ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // idx carries one extra bit so a full-capacity dump ends without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_f        <= 2'd0;
            r_b        <= 4'd0;
            r_addr_fld <= 32'h0000_0000;
            r_data_fld <= 32'h0000_0000;
            r_we_fld   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dump_start_i) begin
                        r_cnt <= w_cnt_clamp;
                        r_idx <= '0;
                        r_f   <= 2'd0;
                    end
                end
                S_RD_CAP: begin
                    case (r_f)
                        2'd0:    r_addr_fld <= trace_rdata_i;
                        2'd1:    r_data_fld <= trace_rdata_i;
                        default: r_we_fld   <= trace_rdata_i[0];
                    endcase
                    if (r_f == 2'd2) begin
                        r_b <= 4'd0;
                    end else begin
                        r_f <= r_f + 2'd1;
                    end
                end
                S_SEND: begin
                    if (tx_ready_i) begin
                        if (r_b == c_LAST_BYTE) begin
                            r_b <= 4'd0;
                            if (!w_last_entry) begin
                                r_idx <= w_idx_inc;
                                r_f   <= 2'd0;
                            end
                        end else begin
                            r_b <= r_b + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_dumper
// Purpose  : Self-checking bench for trace_dumper (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_trace_dumper;

    localparam int CAPACITY = 256;
    localparam int IDX_W    = 8;
`ifdef TRACE_DUMP_CHK_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int PER   = NB + 6;
    localparam int LIMIT = 20000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             dump_start_i = 1'b0;
    logic [IDX_W:0]   entry_cnt_i = '0;
    logic             busy_o, done_o;
    logic             trace_req_o;
    logic             trace_ack = 1'b0;
    logic [31:0]      trace_addr_o;
    logic             trace_we_o;
    logic [31:0]      trace_wdata_o;
    logic [31:0]      trace_rdata = 32'h0;
    logic [7:0]       tx_data_o;
    logic             tx_valid_o;
    logic             tx_ready = 1'b1;

    always #5 clk = ~clk;

    trace_dumper #(.CAPACITY(CAPACITY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dump_start_i (dump_start_i),
        .entry_cnt_i  (entry_cnt_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .trace_req_o  (trace_req_o),
        .trace_ack_i  (trace_ack),
        .trace_addr_o (trace_addr_o),
        .trace_we_o   (trace_we_o),
        .trace_wdata_o(trace_wdata_o),
        .trace_rdata_i(trace_rdata),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_a [CAPACITY];
    logic [31:0] mem_d [CAPACITY];
    logic        mem_w [CAPACITY];

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_addrs[$];
    logic [7:0]  got_bytes[$];
    logic [31:0] got_addrs[$];
    logic [7:0]  ref_bytes[$];

    int   cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    bit   stall_en = 1'b0;
    int   ack_wait = -1;
    bit   hs_pend = 1'b0;
    logic [31:0] hs_addr = 32'h0;
    bit   prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference record builder: reads, then bytes LSB first, flag, optional XOR.
    task automatic push_expect(input int n);
        logic [7:0] rec [10];
        logic [7:0] x;
        for (int e = 0; e < n; e++) begin
            for (int f = 0; f < 3; f++) exp_addrs.push_back(32'(e * 4 + f));
            for (int k = 0; k < 4; k++) rec[k]     = mem_a[e][8*k +: 8];
            for (int k = 0; k < 4; k++) rec[4 + k] = mem_d[e][8*k +: 8];
            rec[8] = {7'b0, mem_w[e]};
            x = 8'h00;
            for (int k = 0; k < 9; k++) x = x ^ rec[k];
            rec[9] = x;
            for (int k = 0; k < NB; k++) exp_bytes.push_back(rec[k]);
        end
    endtask

    // Memory slave, sink and monitors, all working on the falling edge.
    always @(negedge clk) begin
        logic [31:0] junk;
        logic [7:0]  ei;
        cyc++;
        junk = $urandom;
        if (hs_pend) begin
            ei = hs_addr[9:2];
            case (hs_addr[1:0])
                2'd0:    trace_rdata = mem_a[ei];
                2'd1:    trace_rdata = mem_d[ei];
                default: trace_rdata = {junk[31:1], mem_w[ei]};
            endcase
            hs_pend = 1'b0;
        end else begin
            trace_rdata = junk;
        end

        if (rst_n && prev_stall) begin
            check("stall_valid", 32'(tx_valid_o), 32'd1);
            check("stall_data", 32'(tx_data_o), 32'(prev_data));
        end

        if (!trace_req_o) begin
            trace_ack = 1'b0;
            ack_wait  = -1;
        end else begin
            if (ack_wait < 0) ack_wait = stall_en ? int'($urandom_range(0, 3)) : 0;
            trace_ack = (ack_wait == 0);
            if (ack_wait > 0) ack_wait--;
        end
        tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;

        if (rst_n && tx_valid_o && tx_ready) begin
            got_bytes.push_back(tx_data_o);
            if (exp_bytes.size() == 0) begin
                checks++; failures++;
                $display("FAIL extra_byte: got 0x%0h expected none", tx_data_o);
            end else begin
                check("byte", 32'(tx_data_o), 32'(exp_bytes.pop_front()));
            end
        end
        prev_stall = rst_n && tx_valid_o && !tx_ready;
        prev_data  = tx_data_o;

        if (rst_n && trace_req_o && trace_ack) begin
            got_addrs.push_back(trace_addr_o);
            check("rd_we", {31'b0, trace_we_o}, 32'd0);
            if (exp_addrs.size() == 0) begin
                checks++; failures++;
                $display("FAIL extra_read: got 0x%0h expected none", trace_addr_o);
            end else begin
                check("rd_addr", trace_addr_o, exp_addrs.pop_front());
            end
            hs_pend = 1'b1;
            hs_addr = trace_addr_o;
        end
        if (rst_n && dump_start_i && !busy_o) start_cyc = cyc;
        if (rst_n && done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_run();
        exp_bytes.delete(); exp_addrs.delete();
        got_bytes.delete(); got_addrs.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input int cnt);
        @(posedge clk); #1;
        dump_start_i = 1'b1;
        entry_cnt_i  = cnt[IDX_W:0];
        @(posedge clk); #1;
        dump_start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < LIMIT && done_cnt == 0; k++) @(posedge clk);
        if (done_cnt == 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int cnt_in;
        bit stall;
        int exp_rec;
    } vec_t;

    vec_t vecs[6];
    logic [71:0] rec0 = 72'h01_DEADBEEF_10000004;

    initial begin
        vecs[0] = '{cnt_in: 1,   stall: 1'b0, exp_rec: 1};
        vecs[1] = '{cnt_in: 0,   stall: 1'b0, exp_rec: 0};
        vecs[2] = '{cnt_in: 3,   stall: 1'b0, exp_rec: 3};
        vecs[3] = '{cnt_in: 3,   stall: 1'b1, exp_rec: 3};
        vecs[4] = '{cnt_in: 5,   stall: 1'b1, exp_rec: 5};
        vecs[5] = '{cnt_in: 261, stall: 1'b0, exp_rec: 256};

        for (int i = 0; i < CAPACITY; i++) begin
            mem_a[i] = $urandom;
            mem_d[i] = $urandom;
            mem_w[i] = 1'($urandom_range(0, 1));
        end
        mem_a[0] = 32'h1000_0004; mem_d[0] = 32'hDEAD_BEEF; mem_w[0] = 1'b1;
        mem_a[2] = 32'h0000_0020; mem_d[2] = 32'h0000_0005; mem_w[2] = 1'b0;

        #12;
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_valid", 32'(tx_valid_o), 32'd0);
        check("rst_data",  32'(tx_data_o), 32'd0);
        check("rst_req",   32'(trace_req_o), 32'd0);
        check("rst_addr",  trace_addr_o, 32'd0);
        check("rst_wdata", trace_wdata_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            clear_run();
            stall_en = vecs[i].stall;
            push_expect(vecs[i].exp_rec);
            pulse_start(vecs[i].cnt_in);
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d_done_cnt", i), 32'(done_cnt), 32'd1);
            check($sformatf("vec%0d_nbytes", i), 32'(got_bytes.size()), 32'(vecs[i].exp_rec * NB));
            check($sformatf("vec%0d_nreads", i), 32'(got_addrs.size()), 32'(vecs[i].exp_rec * 3));
            check($sformatf("vec%0d_exp_left", i), 32'(exp_bytes.size()), 32'd0);
            check($sformatf("vec%0d_busy_end", i), 32'(busy_o), 32'd0);
            if (!vecs[i].stall)
                check($sformatf("vec%0d_latency", i), 32'(done_cyc - start_cyc),
                      32'(vecs[i].exp_rec * PER + 1));
            if (i == 0) begin
                for (int k = 0; k < 9; k++)
                    check($sformatf("rec0_b%0d", k), 32'(got_bytes[k]), 32'(rec0[8*k +: 8]));
`ifdef TRACE_DUMP_CHK_EN
                check("rec0_chk", 32'(got_bytes[9]), 32'h37);
`endif
                for (int k = 0; k < 3; k++)
                    check($sformatf("rec0_rd%0d", k), got_addrs[k], 32'(k));
            end
            if (i == 1) check("cnt0_no_read", 32'(got_addrs.size()), 32'd0);
            if (i == 2) begin
                for (int k = 0; k < 3; k++)
                    check($sformatf("ent2_rd%0d", k), got_addrs[6 + k], 32'(8 + k));
                check("ent2_flag", 32'(got_bytes[2*NB + 8]), 32'd0);
                ref_bytes = got_bytes;
            end
            if (i == 3) begin
                for (int k = 0; k < 3*NB; k++)
                    check($sformatf("stall_vs_ref_b%0d", k), 32'(got_bytes[k]), 32'(ref_bytes[k]));
            end
            if (i == 5) check("clamp_last_rd", got_addrs[got_addrs.size()-1], 32'h3FE);
        end

        // Start requests while busy, including one in the DONE cycle, are ignored.
        clear_run();
        stall_en = 1'b0;
        push_expect(2);
        pulse_start(2);
        repeat (5) @(posedge clk);
        pulse_start(5);
        for (int k = 0; k < LIMIT && !done_o; k++) @(negedge clk);
        dump_start_i = 1'b1;
        entry_cnt_i  = 9'd4;
        @(posedge clk); #1;
        dump_start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_ign_done_cnt", 32'(done_cnt), 32'd1);
        check("busy_ign_nbytes", 32'(got_bytes.size()), 32'(2 * NB));
        check("busy_ign_busy", 32'(busy_o), 32'd0);
        check("busy_ign_req", 32'(trace_req_o), 32'd0);

        // Reset in the middle of a record.
        clear_run();
        push_expect(1);
        pulse_start(1);
        for (int k = 0; k < 100 && !tx_valid_o; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(tx_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tx_valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_data", 32'(tx_data_o), 32'd0);
        exp_bytes.delete(); exp_addrs.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        check("mid_rst_idle_valid", 32'(tx_valid_o), 32'd0);
        check("mid_rst_idle_busy", 32'(busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
